// File: rtl/clk_duty_if.sv
// Config handshake and waveform outputs of the programmable duty-cycle clock generator.
interface clk_duty_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    logic             cfg_err;
    logic             clk_out;
    logic             period_done;
    logic             busy;

    // Config/control side: requests runs and offers new high/low lengths.
    modport master (
        output en, cfg_valid, cfg_high, cfg_low,
        input  cfg_ready, cfg_err, clk_out, period_done, busy
    );

    // Generator side.
    modport slave (
        input  en, cfg_valid, cfg_high, cfg_low,
        output cfg_ready, cfg_err, clk_out, period_done, busy
    );
endinterface

// File: rtl/clk_duty_ctrl.sv
// Programmable clock/waveform generator: clk_out is high for H clk cycles and low
// for L clk cycles. New H/L values wait in a one-entry pending slot and are only
// applied at a period boundary (or while idle), so the output never glitches.
module clk_duty_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DEF_HIGH = 8,
    parameter int DEF_LOW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    clk_duty_if.slave   bus
);

    localparam logic [CNT_W-1:0] DEF_H = DEF_HIGH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DEF_L = DEF_LOW[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W-1:0] act_high;
    logic [CNT_W-1:0] act_low;
    logic [CNT_W-1:0] pend_high;
    logic [CNT_W-1:0] pend_low;
    logic [CNT_W-1:0] eff_high;
    logic             pend_vld;
    logic             nxt_pend_vld;
    logic             hs;
    logic             cfg_zero;
    logic             cfg_ok;
    logic             boundary;
    logic             apply_now;

    // Handshake decode, apply decision and next-state/counter computation.
    always_comb begin
        hs        = bus.cfg_valid && bus.cfg_ready;
        cfg_zero  = (bus.cfg_high == '0) || (bus.cfg_low == '0);
        cfg_ok    = hs && !cfg_zero;
        boundary  = (state == LOW) && (cnt == '0);
        apply_now = pend_vld && ((state == IDLE) || boundary);
        // A period starting on the apply edge must already use the new high length.
        eff_high  = apply_now ? pend_high : act_high;

        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    nxt_state = HIGH;
                    nxt_cnt   = eff_high - ONE;
                end
            end
            HIGH: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - ONE;
                end else begin
                    nxt_state = LOW;
                    nxt_cnt   = act_low - ONE;
                end
            end
            LOW: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - ONE;
                end else if (bus.en) begin
                    nxt_state = HIGH;
                    nxt_cnt   = eff_high - ONE;
                end else begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase

        // A fresh config refills the slot even if it is being emptied this edge.
        if (cfg_ok) begin
            nxt_pend_vld = 1'b1;
        end else if (apply_now) begin
            nxt_pend_vld = 1'b0;
        end else begin
            nxt_pend_vld = pend_vld;
        end
    end

    // FSM state, counter, active config and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            act_high        <= DEF_H;
            act_low         <= DEF_L;
            pend_vld        <= 1'b0;
            bus.cfg_ready   <= 1'b1;
            bus.cfg_err     <= 1'b0;
            bus.clk_out     <= 1'b0;
            bus.period_done <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= nxt_state;
            cnt             <= nxt_cnt;
            pend_vld        <= nxt_pend_vld;
            bus.cfg_ready   <= !nxt_pend_vld;
            bus.cfg_err     <= hs && cfg_zero && (nxt_state != IDLE);
            bus.clk_out     <= (nxt_state == HIGH);
            bus.period_done <= (nxt_state == LOW) && (nxt_cnt == '0);
            bus.busy        <= (nxt_state != IDLE);
            if (apply_now) begin
                act_high <= pend_high;
                act_low  <= pend_low;
            end
        end
    end

    // Pending slot contents; only meaningful while pend_vld is set.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            pend_high <= bus.cfg_high;
            pend_low  <= bus.cfg_low;
        end
    end

endmodule

// File: tb/tb_clk_duty_ctrl.sv
// Testbench for clk_duty_ctrl: directed stimulus pushes hand-derived expected
// outputs into a queue; a monitor pops and compares one entry per clock.
module tb_clk_duty_ctrl;

    logic clk;
    logic rst_n;

    clk_duty_if #(.CNT_W(8)) bus ();

    clk_duty_ctrl #(.CNT_W(8), .DEF_HIGH(8), .DEF_LOW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector = {clk_out, period_done, cfg_err, cfg_ready, busy}
    typedef struct {
        logic [4:0] v;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Monitor: outputs settle after the rising edge; compare against the next expectation.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = q.pop_front();
            act = {bus.clk_out, bus.period_done, bus.cfg_err, bus.cfg_ready, bus.busy};
            tests++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s: got {clk_out,pd,err,rdy,busy}=%b expected %b at %0t",
                         e.nm, act, e.v, $time);
            end
        end
    end

    // One clock of stimulus: inputs applied here are sampled at the next rising
    // edge, and ex is the output set expected right after that edge.
    task automatic step(input logic r, input logic e, input logic v,
                        input logic [7:0] h, input logic [7:0] l,
                        input logic [4:0] ex, input string nm);
        exp_t x;
        @(negedge clk);
        rst_n         = r;
        bus.en        = e;
        bus.cfg_valid = v;
        bus.cfg_high  = h;
        bus.cfg_low   = l;
        x.v  = ex;
        x.nm = nm;
        q.push_back(x);
    endtask

    // One full period with en held high and no config offered.
    task automatic run_period(input int h, input int l, input logic rdy, input string nm);
        for (int i = 0; i < h; i++)
            step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, {1'b1, 1'b0, 1'b0, rdy, 1'b1}, nm);
        for (int i = 0; i < l; i++)
            step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, {1'b0, (i == l - 1), 1'b0, rdy, 1'b1}, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_high  = 8'd0;
        bus.cfg_low   = 8'd0;

        // 1: reset values, idle, then default 8/2 with latency 1
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 5'b00010, "reset");
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00010, "reset_en");
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 5'b00010, "idle");
        run_period(8, 2, 1'b1, "t1_8_2_a");
        run_period(8, 2, 1'b1, "t1_8_2_b");

        // 2: offer 3/3 on 3rd high cycle; current period finishes as 8/2
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10011, "t2_high");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10011, "t2_high");
        step(1'b1, 1'b1, 1'b1, 8'd3, 8'd3, 5'b10001, "t2_accept");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10001, "t2_high_pend");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00001, "t2_low_pend");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b01001, "t2_done_pend");
        run_period(3, 3, 1'b1, "t2_3_3");

        // 3: zero high field rejected with one error pulse
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10011, "t3_high");
        step(1'b1, 1'b1, 1'b1, 8'd0, 8'd5, 5'b10111, "t3_err");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10011, "t3_high");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00011, "t3_low");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00011, "t3_low");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b01011, "t3_done");

        // 4: program 1/1 -> clk/2
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10011, "t4_high");
        step(1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 5'b10001, "t4_accept");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10001, "t4_high_pend");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00001, "t4_low_pend");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00001, "t4_low_pend");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b01001, "t4_done_pend");
        run_period(1, 1, 1'b1, "t4_1_1");
        run_period(1, 1, 1'b1, "t4_1_1");
        run_period(1, 1, 1'b1, "t4_1_1");

        // 5: back to 8/2, drop en on 3rd high cycle, clean stop, restart
        step(1'b1, 1'b1, 1'b1, 8'd8, 8'd2, 5'b10001, "t5_accept");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b01001, "t5_done_pend");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10011, "t5_high");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10011, "t5_high");
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 5'b10011, "t5_high_en0");
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 5'b00011, "t5_low_en0");
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 5'b01011, "t5_done_en0");
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 5'b00010, "t5_idle");
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 5'b00010, "t5_idle");
        run_period(8, 2, 1'b1, "t5_restart");

        // 6: async reset mid-LOW with 3/3 pending; restart must use 8/2
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10011, "t6_high");
        step(1'b1, 1'b1, 1'b1, 8'd3, 8'd3, 5'b10001, "t6_accept");
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b10001, "t6_high_pend");
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00001, "t6_low_pend");
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00010, "t6_reset");
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 5'b00010, "t6_reset");
        run_period(8, 2, 1'b1, "t6_restart");

        // Let the monitor consume every queued expectation.
        for (int i = 0; i < 4; i++) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
